// File: rtl/lsu_mem_master_if.sv
// Bundle of the core-side request/response handshake and the word-addressed data
// memory port driven by the load/store unit.
interface lsu_mem_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  // Core request / response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  // Data memory
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_rd;

  // The load/store unit
  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wd, mem_we, mem_read
  );

  // The core plus data memory seen from the other side
  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wd, mem_we, mem_read
  );

endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: turns RV32I byte/half/word loads and stores into whole-word accesses
// on a word-addressed data memory. Sub-word stores use read-modify-write; loads are
// sign/zero-extended. One request in flight, one response pulse per accepted request.
module lsu_mem_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 65
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StWr,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;   // only sub-word stores need the latched data
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_bad_funct3;
  logic                  req_misaligned;
  logic                  req_out_of_range;
  logic                  req_err;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rmw_word;
  logic [DATA_WIDTH-1:0] word_idx;

  // Classify the incoming request so the accept cycle can route errors straight to DONE
  always_comb begin
    req_bad_funct3 = 1'b0;
    req_misaligned = 1'b0;
    if (bus.req_write) begin
      req_bad_funct3 = (bus.req_funct3 > 3'b010);
    end else begin
      req_bad_funct3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                       (bus.req_funct3 == 3'b111);
    end
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    req_out_of_range = ((bus.req_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH));
    req_err          = req_bad_funct3 || req_misaligned || req_out_of_range;
  end

  // Extract and extend the addressed lane of the read word, and build the RMW store word
  always_comb begin
    rd_byte   = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    rd_half   = bus.mem_rd[{addr_q[1], 4'b0000} +: 16];
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = bus.mem_rd;
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = '0;
    endcase
    rmw_word = bus.mem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      rmw_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      rmw_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
    word_idx = DATA_WIDTH'(addr_q >> 2);
  end

  // Next-state and latched-request update
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata[15:0];
          merged_d = bus.req_wdata;      // SW writes this directly; SB/SH overwrite it
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err) begin
            state_d = StDone;
          end else if (!bus.req_write) begin
            state_d = StRd;
          end else if (bus.req_funct3[1:0] == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRd: begin
        rdata_d = load_data;
        state_d = StDone;
      end
      StRmwRd: begin
        merged_d = rmw_word;
        state_d  = StWr;
      end
      StWr: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched registers; synchronous reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Output decode; everything is forced low while reset is held so no write can slip out
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wd     = '0;
    bus.mem_we     = 1'b0;
    bus.mem_read   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          bus.req_ready = 1'b1;
        end
        StRd, StRmwRd: begin
          bus.mem_read = 1'b1;
          bus.mem_addr = word_idx;
        end
        StWr: begin
          bus.mem_we   = 1'b1;
          bus.mem_addr = word_idx;
          bus.mem_wd   = merged_q;
        end
        StDone: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rdata_q;
          bus.resp_err   = err_q;
        end
        default: begin
          bus.req_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a 65-word RAM model behind the memory port and
// hand-computed expectations for loads, stores, sub-word RMW, errors and reset abort.
module tb_lsu_mem_master;

  localparam int unsigned Depth = 65;

  logic clk;
  logic rst_n;

  lsu_mem_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_mem_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_DEPTH (Depth)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on posedge; preload port for the bench
  logic [31:0] ram [0:Depth-1];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_idx] <= pre_val;
    end else if (bus.mem_we && bus.mem_addr < Depth) begin
      ram[bus.mem_addr[6:0]] <= bus.mem_wd;
    end
  end

  assign bus.mem_rd = (bus.mem_addr < Depth) ? ram[bus.mem_addr[6:0]] : 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Observations of one transaction, cycle numbers relative to the accept edge
  int          r_lat, r_rd_cyc, r_nrd, r_nwe, r_nresp, r_both;
  logic [31:0] r_rdata, r_rd_addr, r_we_addr, r_we_wd;
  logic        r_err;

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    r_lat = -1; r_rd_cyc = -1; r_nrd = 0; r_nwe = 0; r_nresp = 0; r_both = 0;
    r_rdata = '0; r_err = 1'b0; r_rd_addr = '0; r_we_addr = '0; r_we_wd = '0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    // Scramble the request fields: only the latched copies may matter now
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFC;
    bus.req_wdata  = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_we) r_both++;
      if (bus.mem_read) begin
        r_nrd++;
        r_rd_addr = bus.mem_addr;
        if (r_rd_cyc < 0) r_rd_cyc = cyc;
      end
      if (bus.mem_we) begin
        r_nwe++;
        r_we_addr = bus.mem_addr;
        r_we_wd   = bus.mem_wd;
      end
      if (bus.resp_valid) begin
        r_nresp++;
        if (r_lat < 0) begin
          r_lat   = cyc;
          r_rdata = bus.resp_rdata;
          r_err   = bus.resp_err;
        end
      end
    end
  endtask

  task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
    run_req(1'b0, f3, addr, 32'h0);
    check_eq({tag, " lat"},   r_lat, 32'd2);
    check_eq({tag, " rdata"}, r_rdata, exp);
    check_eq({tag, " err"},   {31'h0, r_err}, 32'd0);
    check_eq({tag, " resp"},  r_nresp, 32'd1);
  endtask

  task automatic check_error(input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] addr);
    run_req(w, f3, addr, 32'h1234_5678);
    check_eq({tag, " lat"},   r_lat, 32'd1);
    check_eq({tag, " err"},   {31'h0, r_err}, 32'd1);
    check_eq({tag, " rdata"}, r_rdata, 32'd0);
    check_eq({tag, " mem"},   r_nrd + r_nwe, 32'd0);
  endtask

  int seen_resp;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    pre_en         = 1'b0;
    pre_idx        = '0;
    pre_val        = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < int'(Depth); i++) preload(7'(i), 32'h0);

    // Reset state
    @(negedge clk);
    check_eq("rst req_ready", {31'h0, bus.req_ready}, 32'd0);
    check_eq("rst resp_valid", {31'h0, bus.resp_valid}, 32'd0);
    check_eq("rst mem_rw", {30'h0, bus.mem_read, bus.mem_we}, 32'd0);
    check_eq("rst mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post-rst req_ready", {31'h0, bus.req_ready}, 32'd1);

    // T1: LW
    preload(7'd9, 32'd33);
    run_req(1'b0, 3'b010, 32'h24, 32'h0);
    check_eq("T1 rd cycle", r_rd_cyc, 32'd1);
    check_eq("T1 rd addr", r_rd_addr, 32'd9);
    check_eq("T1 lat", r_lat, 32'd2);
    check_eq("T1 rdata", r_rdata, 32'd33);
    check_eq("T1 err", {31'h0, r_err}, 32'd0);
    check_eq("T1 no write", r_nwe, 32'd0);

    // T2: SW then LW
    run_req(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
    check_eq("T2 we count", r_nwe, 32'd1);
    check_eq("T2 we addr", r_we_addr, 32'd5);
    check_eq("T2 we wd", r_we_wd, 32'hDEAD_BEEF);
    check_eq("T2 no read", r_nrd, 32'd0);
    check_eq("T2 lat", r_lat, 32'd2);
    check_eq("T2 rdata", r_rdata, 32'd0);
    check_load("T2 LW", 3'b010, 32'h14, 32'hDEAD_BEEF);

    // T3: SB via RMW, then LB / LBU
    preload(7'd5, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h15, 32'h0000_00AA);
    check_eq("T3 SB lat", r_lat, 32'd3);
    check_eq("T3 SB reads", r_nrd, 32'd1);
    check_eq("T3 SB writes", r_nwe, 32'd1);
    check_eq("T3 SB wd", r_we_wd, 32'h1122_AA44);
    check_eq("T3 SB never both", r_both, 32'd0);
    check_eq("T3 RAM[5]", ram[5], 32'h1122_AA44);
    check_load("T3 LB", 3'b000, 32'h15, 32'hFFFF_FFAA);
    check_load("T3 LBU", 3'b100, 32'h15, 32'h0000_00AA);
    check_load("T3 LBU lane3", 3'b100, 32'h17, 32'h0000_0011);

    // T4: halfwords
    preload(7'd5, 32'h8122_AA44);
    check_load("T4 LH", 3'b001, 32'h16, 32'hFFFF_8122);
    check_load("T4 LHU", 3'b101, 32'h16, 32'h0000_8122);
    run_req(1'b1, 3'b001, 32'h14, 32'h0000_5678);
    check_eq("T4 SH lat", r_lat, 32'd3);
    check_eq("T4 RAM[5]", ram[5], 32'h8122_5678);
    check_load("T4 LH low", 3'b001, 32'h14, 32'h0000_5678);

    // T5: errors and the last legal word
    check_error("T5 LW misaligned", 1'b0, 3'b010, 32'h16);
    check_error("T5 load f3=011", 1'b0, 3'b011, 32'h20);
    check_error("T5 LW word 65", 1'b0, 3'b010, 32'h104);
    check_error("T5 store f3=100", 1'b1, 3'b100, 32'h20);
    check_error("T5 SH misaligned", 1'b1, 3'b001, 32'h21);
    preload(7'd64, 32'hCAFE_F00D);
    check_load("T5 LW word 64", 3'b010, 32'h100, 32'hCAFE_F00D);

    // T6: reset during the WR cycle of an SB
    preload(7'd5, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("T6 we in reset", {31'h0, bus.mem_we}, 32'd0);
    check_eq("T6 resp in reset", {31'h0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("T6 ready after rst", {31'h0, bus.req_ready}, 32'd1);
    seen_resp = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid || bus.mem_we) seen_resp++;
      @(negedge clk);
    end
    check_eq("T6 no late activity", seen_resp, 32'd0);
    check_eq("T6 RAM[5] unchanged", ram[5], 32'h1122_3344);
    check_load("T6 LW after", 3'b010, 32'h14, 32'h1122_3344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
